// File: rtl/sound_pkg.sv
// Shared constants for the Bricks sound path: note half-period table and tone FSM states.
package sound_pkg;

    localparam int NUM_NOTES = 10;
    localparam int MAX_NOTE  = 9;

    // Half-periods in 50 MHz cycles, C5 (index 0) up to E6 (index 9).
    localparam logic [16:0] HALF_PERIOD [NUM_NOTES] = '{
        17'd47778, 17'd42565, 17'd37921, 17'd35793, 17'd31888,
        17'd28409, 17'd25310, 17'd23889, 17'd21282, 17'd18961
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } tone_state_t;

    function automatic logic [3:0] clamp_note(input logic [3:0] sel);
        return (sel > 4'(MAX_NOTE)) ? 4'(MAX_NOTE) : sel;
    endfunction

endpackage

// File: rtl/tone_rom.sv
// Note-index to half-period lookup; isolated so the note table can change without touching the FSM.
module tone_rom
    import sound_pkg::*;
#(
    parameter int HALF_W = 17
) (
    input  logic [3:0]        note_idx,
    output logic [HALF_W-1:0] half_period
);

    always_comb begin
        half_period = HALF_W'(HALF_PERIOD[MAX_NOTE]);
        if (note_idx <= 4'(MAX_NOTE))
            half_period = HALF_W'(HALF_PERIOD[note_idx]);
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator gated by the duration counter's tc; the last high phase always completes.
// Optional descending sweep compiled in with `define TONE_SWEEP_EN.
module tone_generator
    import sound_pkg::*;
#(
    parameter int HALF_W      = 17,
    parameter int SWEEP_TICKS = 2_500_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ena,
    input  logic       sound_en,
    input  logic [3:0] tone_sel,
    output logic       sound_out,
    output logic       tone_active,
    output logic [3:0] note_idx
);

    localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

    tone_state_t       state_q;
    logic [HALF_W-1:0] cnt_q;
    logic              sound_out_q;
    logic              active_q;
    logic [3:0]        note_q;
    logic [3:0]        rom_idx;
    logic [HALF_W-1:0] half;
    logic              cnt_zero;

    // In IDLE the ROM looks up the incoming selection so the first phase loads in the same edge.
    assign rom_idx  = (state_q == ST_IDLE) ? clamp_note(tone_sel) : note_q;
    assign cnt_zero = (cnt_q == '0);

    tone_rom #(.HALF_W(HALF_W)) u_rom (
        .note_idx    (rom_idx),
        .half_period (half)
    );

`ifdef TONE_SWEEP_EN
    localparam int SW_W = $clog2(SWEEP_TICKS + 1);
    logic [SW_W-1:0] sweep_q;
    logic            sweep_hit;
    assign sweep_hit = (sweep_q == SW_W'(SWEEP_TICKS - 1));
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sound_out_q <= 1'b0;
            active_q    <= 1'b0;
            note_q      <= '0;
`ifdef TONE_SWEEP_EN
            sweep_q     <= '0;
`endif
        end else if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (sound_en) begin
                        state_q     <= ST_PLAY;
                        active_q    <= 1'b1;
                        note_q      <= clamp_note(tone_sel);
                        sound_out_q <= 1'b1;
                        cnt_q       <= half - ONE;
`ifdef TONE_SWEEP_EN
                        sweep_q     <= '0;
`endif
                    end
                end
                ST_PLAY: begin
                    cnt_q <= cnt_zero ? (half - ONE) : (cnt_q - ONE);
                    // Stop at once if already low, or if this edge ends a high phase.
                    if (!sound_en && (!sound_out_q || cnt_zero)) begin
                        state_q     <= ST_IDLE;
                        active_q    <= 1'b0;
                        sound_out_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        if (cnt_zero)
                            sound_out_q <= ~sound_out_q;
                        if (!sound_en)
                            state_q <= ST_DRAIN;
                    end
`ifdef TONE_SWEEP_EN
                    sweep_q <= sweep_hit ? '0 : (sweep_q + SW_W'(1));
                    if (sweep_hit && note_q != 4'd0)
                        note_q <= note_q - 4'd1;
`endif
                end
                ST_DRAIN: begin
                    if (cnt_zero) begin
                        state_q     <= ST_IDLE;
                        active_q    <= 1'b0;
                        sound_out_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    active_q    <= 1'b0;
                    sound_out_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign sound_out   = sound_out_q;
    assign tone_active = active_q;
    assign note_idx    = note_q;

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: play sessions are turned into expected edge timestamps.
module tb_tone_generator;

    logic       clk = 1'b0;
    logic       resetN, ena, sound_en;
    logic [3:0] tone_sel;
    logic       sound_out, tone_active;
    logic [3:0] note_idx;

    always #10 clk = ~clk;

    tone_generator dut (
        .clk         (clk),
        .resetN      (resetN),
        .ena         (ena),
        .sound_en    (sound_en),
        .tone_sel    (tone_sel),
        .sound_out   (sound_out),
        .tone_active (tone_active),
        .note_idx    (note_idx)
    );

    int HALF_T [10] = '{47778, 42565, 37921, 35793, 31888, 28409, 25310, 23889, 21282, 18961};

    typedef enum int {EV_TA_RISE, EV_SO_RISE, EV_SO_FALL, EV_TA_FALL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        longint   t;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    longint     en_cnt = 0;   // count of enabled clock edges seen since time 0
    bit         mon_en = 1'b0;
    bit         last_ena = 1'b0;
    logic [3:0] exp_note = '0;
    logic       so_p = 1'b0, ta_p = 1'b0;
    logic [3:0] ni_p = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic match(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(k), 64'hFFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            check("event_time", 64'(en_cnt), 64'(e.t));
        end
    endtask

    always @(posedge clk) begin
        last_ena = ena;
        if (ena && resetN) en_cnt++;
    end

    // Monitor: turns output edges into events and checks them against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!last_ena)
                check("freeze_hold", {58'd0, sound_out, tone_active, note_idx}, {58'd0, so_p, ta_p, ni_p});
            if (tone_active && !ta_p) match(EV_TA_RISE);
            if (sound_out && !so_p)   match(EV_SO_RISE);
            if (!sound_out && so_p)   match(EV_SO_FALL);
            if (!tone_active && ta_p) match(EV_TA_FALL);
            if (tone_active && (sound_out !== so_p || tone_active !== ta_p))
                check("note_idx", 64'(note_idx), 64'(exp_note));
        end
        so_p = sound_out;
        ta_p = tone_active;
        ni_p = note_idx;
    end

    // One play request: sound_en high for D enabled edges, optional freeze, tone_sel changed mid-play.
    task automatic session(input int sel, input int sel2, input int D, input int frz_at, input int frz_len);
        int     idx, H, E, issued, frz_left;
        longint S;
        idx = (sel > 9) ? 9 : sel;
        H   = HALF_T[idx];
        // High when sound_en drops: finish that high phase. Low: stop right there.
        E   = (((D - 1) / H) % 2 == 0) ? H * ((D + H - 1) / H) : D;
        S   = en_cnt + 1;
        exp_note = 4'(idx);
        exp_q.push_back('{kind: EV_TA_RISE, t: S});
        exp_q.push_back('{kind: EV_SO_RISE, t: S});
        for (int m = 1; m * H <= E; m++) begin
            if (m % 2 == 1)
                exp_q.push_back('{kind: EV_SO_FALL, t: S + longint'(m * H)});
            else if (m * H < D)
                exp_q.push_back('{kind: EV_SO_RISE, t: S + longint'(m * H)});
        end
        exp_q.push_back('{kind: EV_TA_FALL, t: S + longint'(E)});

        tone_sel = 4'(sel);
        issued   = 0;
        frz_left = frz_len;
        while (issued <= E + 2) begin
            if (issued == frz_at && frz_left > 0) begin
                ena = 1'b0;
                frz_left--;
            end else begin
                ena      = 1'b1;
                sound_en = (issued < D);
                issued++;
            end
            if (issued == 50) tone_sel = 4'(sel2);
            @(negedge clk);
        end
        ena      = 1'b1;
        sound_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int sel, H, D, fa;
        resetN   = 1'b0;
        ena      = 1'b1;
        sound_en = 1'b0;
        tone_sel = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_sound_out",   64'(sound_out),   64'd0);
        check("rst_tone_active", 64'(tone_active), 64'd0);
        check("rst_note_idx",    64'(note_idx),    64'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a high phase.
        tone_sel = 4'd4;
        sound_en = 1'b1;
        @(negedge clk);
        check("start_latency", 64'(sound_out), 64'd1);
        check("start_note",    64'(note_idx),  64'd4);
        repeat (200) @(negedge clk);
        check("mid_play_high", 64'(sound_out), 64'd1);
        resetN = 1'b0;
        #1;
        check("async_rst_sound_out",   64'(sound_out),   64'd0);
        check("async_rst_tone_active", 64'(tone_active), 64'd0);
        check("async_rst_note_idx",    64'(note_idx),    64'd0);
        sound_en = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 64'({sound_out, tone_active}), 64'd0);

        mon_en = 1'b1;
        @(negedge clk);

        // Clamp 12 -> 9, tone_sel change ignored, sound_en drops during a low phase.
        session(12, 2, HALF_T[9] + int'($urandom_range(1, 300)), -1, 0);

        // Random high note, drop while high (drain), 1000-cycle freeze inside the phase.
        sel = int'($urandom_range(6, 9));
        H   = HALF_T[sel];
        D   = int'($urandom_range(100, H - 1));
        fa  = int'($urandom_range(200, H - 200));
        session(sel, int'($urandom_range(0, 15)), D, fa, 1000);

        // sound_en falls on the very edge that ends the first high phase.
        session(9, 0, HALF_T[9], -1, 0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
# tone_generator

Audio tone generator sitting directly downstream of the sound-duration down counter in the Bricks game sound path. Consumes the counter's "sound enable" output (`tc`) and the same 4-bit note code used to load it, and produces a square wave on the speaker pin for as long as the enable is held. Guarantees a clean ending: the last high half-period is never truncated.

## Interface
- `HALF_W`, 17: width of half-period counter; must hold the largest table entry (47778).
- `SWEEP_TICKS`, 2_500_000: cycles per sweep step (used only when the sweep feature is compiled in).
- `clk` in 1: system clock, 50 MHz.
- `resetN` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; when low, all state and outputs freeze.
- `sound_en` in 1: play request, driven by the down counter's `tc`.
- `tone_sel` in 4: note code 0..9; latched at the start of play.
- `sound_out` out 1: square wave to the speaker.
- `tone_active` out 1: high in PLAY and DRAIN.
- `note_idx` out 4: note currently being played.

## Operation
- Note half-periods in cycles at 50 MHz, indices 0..9:
  - 47778 (C5), 42565, 37921, 35793, 31888, 28409 (A5), 25310, 23889, 21282, 18961 (E6).
- `tone_sel` > 9 is clamped to 9 when latched.
- FSM states: IDLE, PLAY, DRAIN.
- IDLE to PLAY:
  - Occurs when `sound_en` is 1 (with `ena` = 1).
  - Latch `note_idx` = clamp(`tone_sel`).
  - Set `sound_out` to 1 and load `cnt` with HALF[idx]-1.
- PLAY behaviour:
  - Decrement `cnt` each enabled cycle.
  - At `cnt` == 0: toggle `sound_out` and reload HALF[`note_idx`]-1.
- PLAY, `sound_en` = 0:
  - If `sound_out` is 0: go to IDLE next cycle.
  - If `sound_out` is 1: go to DRAIN and keep counting.
  - If the same cycle also hits `cnt` == 0, the toggle to 0 wins and the next state is IDLE.
- DRAIN behaviour:
  - At `cnt` == 0: `sound_out` goes to 0 and the next state is IDLE.
  - `sound_en` reassertion in DRAIN is ignored; it is re-evaluated in IDLE, which re-latches `tone_sel`.
- Changes to `tone_sel` during PLAY or DRAIN are ignored.
- `ena` = 0 holds state, `cnt`, `sound_out` and `note_idx` unchanged, whatever the other inputs.
- Reset mid-play: outputs drop to reset values immediately (asynchronous).

## Timing
- Reset values:
  - state IDLE
  - `sound_out` 0
  - `tone_active` 0
  - `note_idx` 0
  - `cnt` 0
- Latency: `sound_out` rises on the first `clk` edge after `sound_en` is sampled high in IDLE (1 cycle).
- Each high and each low phase lasts exactly HALF[idx] enabled cycles, so the period is 2×HALF.
- `tone_active` is registered and rises and falls on the same edges as the state register.
- Worst-case tail after `sound_en` falls: HALF[idx] cycles in DRAIN.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `TONE_SWEEP_EN`.
- With the macro defined:
  - In PLAY, a `sweep_cnt` counts SWEEP_TICKS enabled cycles.
  - On expiry, `note_idx` decrements by 1, saturating at 0, and subsequent reloads use the new half-period.
  - The current half-period is not cut short.
  - `sweep_cnt` clears on IDLE to PLAY.
  - Gives a descending "chirp" on brick hits.
- Without the macro: `note_idx` is constant for the whole play, and no sweep logic or counter is present.

## Structure
- Package `sound_pkg`:
  - `NUM_NOTES` = 10
  - `MAX_NOTE` = 9
  - the 10-entry half-period constant array
  - FSM state enum `tone_state_t`
- Sub-module `tone_rom`:
  - Input: `note_idx`.
  - Output: `half_period` of HALF_W bits, read from the package array.
  - Out-of-range indices return entry 9.
  - Kept separate so the note table can change without touching the FSM.

## Test plan
- Reset:
  - Assert `resetN` = 0 mid-PLAY, with `sound_out` = 1.
  - Expect `sound_out`, `tone_active` and `note_idx` at 0 in the same cycle, and state IDLE after release.
- Basic play:
  - Stimulus: `tone_sel` = 5, `sound_en` held high.
  - Expect `sound_out` high 1 cycle later.
  - Expect high for 28409 cycles, low for 28409 cycles, and repeat.
- Clean drain:
  - Stimulus: drop `sound_en` 100 cycles into a high phase at note 0.
  - Expect `sound_out` to stay high until 47778 cycles into the phase, then go low with `tone_active` 0 and state IDLE.
- Clamp and ignore:
  - Stimulus: `tone_sel` = 12 at start, then change `tone_sel` to 2 during PLAY.
  - Expect `note_idx` = 9 throughout and a half-period of 18961.
- Freeze:
  - Stimulus: `ena` = 0 for 1000 cycles mid-phase.
  - Expect the phase to stretch by exactly 1000 cycles, with no toggle and unchanged outputs.
- Sweep (`TONE_SWEEP_EN`, SWEEP_TICKS = 100000):
  - Stimulus: `tone_sel` = 3.
  - Expect `note_idx` to step 3, 2, 1, 0 at 100000-cycle intervals, then hold at 0.
